// File: rtl/race_if.sv
// Handshake and status signals between the match controller and its
// surroundings: buttons, network receive/transmit and the kart datapath.
interface race_if;
    logic       btnu;
    logic       frame_tick;
    logic       opp_valid;
    logic [2:0] opp_game;
    logic       cp_valid;
    logic [1:0] cp_id;
    logic [2:0] game_stat;
    logic       race_active;
    logic       load_start;
    logic [2:0] laps;
    logic [1:0] countdown_digit;

    modport master (
        output btnu, frame_tick, opp_valid, opp_game, cp_valid, cp_id,
        input  game_stat, race_active, load_start, laps, countdown_digit
    );

    modport slave (
        input  btnu, frame_tick, opp_valid, opp_game, cp_valid, cp_id,
        output game_stat, race_active, load_start, laps, countdown_digit
    );
endinterface

// File: rtl/race_controller.sv
// Two-player kart match sequencer: ready handshake with the opponent,
// frame-timed 3-2-1 countdown, ordered-checkpoint lap counting, win/loss.
module race_controller #(
    parameter int NUM_LAPS         = 3,
    parameter int FRAMES_PER_DIGIT = 60
) (
    input logic clk,
    input logic btnc,
    race_if.slave bus
);
    localparam int CW = (FRAMES_PER_DIGIT > 1) ? $clog2(FRAMES_PER_DIGIT) : 1;
    localparam logic [CW-1:0] LAST_FRAME = CW'(FRAMES_PER_DIGIT - 1);
    localparam logic [2:0]    LAPS_GOAL  = 3'(NUM_LAPS);

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_COUNT, S_RACE, S_WON, S_LOST
    } state_t;

    state_t        state, state_d;
    logic [2:0]    game_stat, game_stat_d;
    logic          race_active, race_active_d;
    logic          load_start, load_start_d;
    logic [2:0]    laps, laps_d;
    logic [1:0]    digit, digit_d;
    logic [2:0]    opp_stat, opp_stat_d;
    logic [1:0]    next_cp, next_cp_d;
    logic [CW-1:0] frame_cnt, frame_cnt_d;
    logic          btnu_q;
    logic          press;

    assign press = bus.btnu & ~btnu_q;

    always_ff @(posedge clk) begin
        if (btnc) begin
            state       <= S_IDLE;
            game_stat   <= 3'd0;
            race_active <= 1'b0;
            load_start  <= 1'b0;
            laps        <= 3'd0;
            digit       <= 2'd0;
            opp_stat    <= 3'd0;
            next_cp     <= 2'd0;
            frame_cnt   <= '0;
            btnu_q      <= 1'b0;
        end else begin
            state       <= state_d;
            game_stat   <= game_stat_d;
            race_active <= race_active_d;
            load_start  <= load_start_d;
            laps        <= laps_d;
            digit       <= digit_d;
            opp_stat    <= opp_stat_d;
            next_cp     <= next_cp_d;
            frame_cnt   <= frame_cnt_d;
            btnu_q      <= bus.btnu;
        end
    end

    always_comb begin
        state_d       = state;
        game_stat_d   = game_stat;
        race_active_d = race_active;
        load_start_d  = 1'b0;
        laps_d        = laps;
        digit_d       = digit;
        opp_stat_d    = bus.opp_valid ? bus.opp_game : opp_stat;
        next_cp_d     = next_cp;
        frame_cnt_d   = frame_cnt;

        case (state)
            S_IDLE: begin
                if (press) begin
                    state_d     = S_READY;
                    game_stat_d = 3'd1;
                end
            end
            S_READY: begin
                if (opp_stat == 3'd1 || opp_stat == 3'd3) begin
                    state_d      = S_COUNT;
                    load_start_d = 1'b1;
                    digit_d      = 2'd3;
                    frame_cnt_d  = '0;
                    laps_d       = 3'd0;
                end
            end
            S_COUNT: begin
                // game_stat stays READY so the opponent's handshake still holds
                if (bus.frame_tick) begin
                    if (frame_cnt == LAST_FRAME) begin
                        frame_cnt_d = '0;
                        if (digit == 2'd1) begin
                            state_d       = S_RACE;
                            digit_d       = 2'd0;
                            race_active_d = 1'b1;
                            next_cp_d     = 2'd1;
                            game_stat_d   = 3'd3;
                        end else begin
                            digit_d = digit - 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt + 1'b1;
                    end
                end
            end
            S_RACE: begin
                // Opponent's win was reported first, so it beats our own finish
                if (opp_stat == 3'd2) begin
                    state_d       = S_LOST;
                    game_stat_d   = 3'd4;
                    race_active_d = 1'b0;
                end else if (laps == LAPS_GOAL) begin
                    state_d       = S_WON;
                    game_stat_d   = 3'd2;
                    race_active_d = 1'b0;
                end else if (bus.cp_valid && bus.cp_id == next_cp) begin
                    next_cp_d = next_cp + 2'd1;
                    if (bus.cp_id == 2'd0)
                        laps_d = laps + 3'd1;
                end
            end
            S_WON, S_LOST: begin
                if (press) begin
                    state_d     = S_IDLE;
                    game_stat_d = 3'd0;
                    laps_d      = 3'd0;
                    opp_stat_d  = 3'd0;
                end
            end
            default: begin
                state_d       = S_IDLE;
                game_stat_d   = 3'd0;
                race_active_d = 1'b0;
                digit_d       = 2'd0;
            end
        endcase
    end

    assign bus.game_stat       = game_stat;
    assign bus.race_active     = race_active;
    assign bus.load_start      = load_start;
    assign bus.laps            = laps;
    assign bus.countdown_digit = digit;
endmodule

// File: doc/race_controller.md
# race_controller

Sequences one two-player kart match. Gates the kart motion datapath through `race_active`, triggers a reload of start positions, counts laps from ordered checkpoint hits, and resolves win/loss against the opponent's status received over the network link. It sits between the user buttons and network receive path on one side, and the kart position/turning logic and the network transmit path (`game_stat`) on the other.

## Interface
Parameters:
- `NUM_LAPS`, default 3: number of laps to finish; range 1–7.
- `FRAMES_PER_DIGIT`, default 60: number of `frame_tick` pulses each countdown digit is shown.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `btnc`, in, 1: reset; synchronous, active-high.
- `btnu`, in, 1: player "ready/continue" button, already debounced.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `opp_valid`, in, 1: one-cycle strobe; a received opponent packet is valid.
- `opp_game`, in, 3: opponent status in the received packet; sampled only when `opp_valid`=1.
- `cp_valid`, in, 1: one-cycle strobe; the player kart entered a checkpoint region.
- `cp_id`, in, 2: checkpoint index 0–3; checkpoint 0 is the start/finish line.
- `game_stat`, out, 3: local status, sent to the opponent. 0=IDLE, 1=READY, 2=WON, 3=RACING, 4=LOST.
- `race_active`, out, 1: enables kart motion and turning.
- `load_start`, out, 1: one-cycle pulse; position logic reloads the start coordinates.
- `laps`, out, 3: laps completed.
- `countdown_digit`, out, 2: digit to display (3, 2, 1); 0 when no countdown is running.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `game_stat`=0, `race_active`=0, `load_start`=0, `laps`=0, `countdown_digit`=0. Internal registers also reset: `opp_stat`=0, `next_cp`=0, frame counter 0, `btnu_q`=0.
- `btnu_q` registers `btnu`. A press is `btnu & ~btnu_q` (rising edge only); holding the button produces a single press.
- `opp_stat` loads `opp_game` on every `opp_valid`, in every state. It is cleared to 0 on entry to IDLE. If the clear and `opp_valid` occur in the same cycle, the clear wins.

State machine:
- IDLE: `game_stat`=0. On a press, go to READY.
- READY: `game_stat`=1.
  - If `opp_stat` is 1 or 3, go to COUNTDOWN. In the same cycle assert `load_start`, set `countdown_digit`=3, clear the frame counter, and clear `laps`.
- COUNTDOWN: `game_stat` stays 1, so the opponent still sees READY.
  - Each `frame_tick` increments the frame counter.
  - When the counter reaches `FRAMES_PER_DIGIT`-1 on a tick, clear the counter and decrement the digit.
  - When the digit is 1 at that point, go to RACE. Set `countdown_digit`=0, `race_active`=1, and `next_cp`=1.
- RACE: `game_stat`=3, `race_active`=1.
  - When `cp_valid`=1 and `cp_id`==`next_cp`: set `next_cp` to (`next_cp`+1) mod 4.
  - If that matched `cp_id` is 0, also increment `laps`.
  - `cp_valid` with any other `cp_id` is ignored. This covers reversing and skipping checkpoints.
  - When `laps`==`NUM_LAPS`, go to WON, evaluated on the registered `laps` one cycle after the increment.
  - When `opp_stat`==2, go to LOST.
  - If both conditions hold in the same cycle, go to LOST. The opponent's report was received earlier.
- WON: `game_stat`=2. LOST: `game_stat`=4.
  - In both, `race_active`=0 from the transition cycle onward.
  - `laps` holds its value.
  - On a press, go to IDLE and clear `laps`.
- `cp_valid` is ignored outside RACE. `frame_tick` is ignored outside COUNTDOWN. A press is ignored in READY, COUNTDOWN and RACE.
- Reset in any state, including mid-countdown or mid-race, returns every register to its reset value on the next edge.
- Encodings 5–7 on `opp_game` are latched but match no condition.

## Timing
- Every transition takes effect on the clock edge after the condition is sampled. Outputs update on that same edge.
- Press to READY: `game_stat` is 1 at edge N+1 after the press cycle N.
- `opp_valid` (cycle N) to COUNTDOWN: `opp_stat` updates at N+1. State and `load_start` update at N+2. `load_start` is high for exactly one cycle.
- Countdown length: exactly 3×`FRAMES_PER_DIGIT` `frame_tick` pulses. `race_active` rises at the edge after the final tick.
- Lap completion: `laps` increments at N+1 after the `cp_valid` cycle N. `game_stat`=2 at N+2.
- The checkpoint and opponent inputs have no back-pressure. Strobes are single-cycle and must not be held.

## Test plan
- Reset, then idle with no stimulus: all outputs 0. Holding `btnu` high for 10 cycles enters READY once; `game_stat`=1.
- READY, then `opp_valid` with `opp_game`=1: `load_start` pulses once two cycles later. With `FRAMES_PER_DIGIT`=2, `countdown_digit` steps 3,2,1 every 2 ticks. `race_active`=1 after the 6th tick, and `game_stat`=3.
- RACE with `NUM_LAPS`=2, checkpoints 1,2,3,0 applied twice: `laps`=1, then 2. `game_stat`=2 two cycles after the final hit. `race_active`=0.
- RACE with out-of-order hits 2,1,0,3,0: only `cp_id`=1 advances `next_cp`; `laps` stays 0.
- RACE with `opp_game`=2 received in the same cycle as the final lap completion: `game_stat`=4 (LOST), not 2. A later press returns to IDLE with `laps`=0.
- `btnc` asserted mid-countdown (digit 2): next edge `game_stat`=0, `countdown_digit`=0. A stale `opp_stat` does not re-trigger a countdown until a new packet arrives and a new press is made.
